// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: shared encodings for the pipelined adder/subtractor
package pipelined_adder_pkg;
    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;
endpackage

// File: rtl/pipelined_adder_slice.sv
// adder_slice: combinational SW-bit ripple chain built from fulladder cells
module fulladder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    assign sum = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module adder_slice #(
    parameter int SW = 4
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          c_in,
    output logic [SW-1:0] sum,
    output logic          c_out,
    output logic          c_msb_in
);
    logic [SW:0] c;
    assign c[0] = c_in;
    for (genvar i = 0; i < SW; i++) begin : g_fa
        fulladder u_fa (.a(a[i]), .b(b[i]), .c_in(c[i]), .sum(sum[i]), .c_out(c[i+1]));
    end
    assign c_out = c[SW];
    assign c_msb_in = c[SW-1];
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/sub split into STAGES registered ripple slices
// with valid/ready flow control; one slice of carry resolved per stage.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int SW = WIDTH / STAGES;

    logic adv;
    logic v [STAGES];
    logic c [STAGES];
    logic s [STAGES];
    logic m [STAGES];
    logic [WIDTH-1:0] x [STAGES];
    logic [WIDTH-1:0] y [STAGES];

    assign adv = !out_valid || out_ready;
    assign in_ready = adv;

    // x rotates right one slice per stage: the unprocessed operand A slices sit at
    // the bottom and finished sum slices enter at the top, so after the last stage
    // x holds the aligned result. y shifts the remaining operand B slices down.
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic vi, ci, si, co, cm;
        logic [WIDTH-1:0] xi, yi;
        logic [SW-1:0] ps;
        if (k == 0) begin : g_in
            assign vi = in_valid;
            assign xi = a;
            assign yi = (sub == ADD) ? b : ~b;
            assign ci = (sub == SUB) ? ~c_in : c_in;
            assign si = sub;
        end else begin : g_in
            assign vi = v[k-1];
            assign xi = x[k-1];
            assign yi = y[k-1];
            assign ci = c[k-1];
            assign si = s[k-1];
        end
        adder_slice #(.SW(SW)) u_slice (
            .a(xi[SW-1:0]),
            .b(yi[SW-1:0]),
            .c_in(ci),
            .sum(ps),
            .c_out(co),
            .c_msb_in(cm)
        );
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v[k] <= 1'b0;
                x[k] <= '0;
                y[k] <= '0;
                c[k] <= 1'b0;
                s[k] <= 1'b0;
                m[k] <= 1'b0;
            end else if (adv) begin
                v[k] <= vi;
                x[k] <= (xi >> SW) | (WIDTH'(ps) << (WIDTH - SW));
                y[k] <= yi >> SW;
                c[k] <= co;
                s[k] <= si;
                m[k] <= cm;
            end
        end
    end

    assign out_valid = v[STAGES-1];
    assign sum = x[STAGES-1];
    // In subtract mode the raw carry is inverted so 1 reads as a borrow.
    assign c_out = c[STAGES-1] ^ s[STAGES-1];
    assign ovf = c[STAGES-1] ^ m[STAGES-1];
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed and random checks of pipelined_adder against an
// integer-arithmetic reference, at 16/4, 4/1 and 8/8 configurations.
module tb_pipelined_adder;
    import pipelined_adder_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf;
    logic [15:0] a, b, sum;
    logic [17:0] obs;
    assign obs = {c_out, ovf, sum};

    logic iv1, ir1, ci1, sb1, ov1, co1, of1;
    logic [3:0] a1, b1, s1;
    logic iv8, ir8, ci8, sb8, ov8, co8, of8;
    logic [7:0] a8, b8, s8;

    int n_tests = 0;
    int n_fail = 0;
    int npop = 0;
    logic [17:0] exp_q[$];

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    pipelined_adder #(.WIDTH(4), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .c_in(ci1), .sub(sb1), .out_valid(ov1),
        .out_ready(1'b1), .sum(s1), .c_out(co1), .ovf(of1)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .c_in(ci8), .sub(sb8), .out_valid(ov8),
        .out_ready(1'b1), .sum(s8), .c_out(co8), .ovf(of8)
    );

    // Reference result packed as {c_out, ovf, 16-bit zero-extended sum}.
    function automatic logic [17:0] model(int w, longint ua, longint ub, bit ci, bit sb);
        longint m, h, r, sa, sbv, sr, cl;
        logic [17:0] res;
        m = longint'(1) << w;
        h = m / 2;
        cl = ci;
        sa = (ua >= h) ? ua - m : ua;
        sbv = (ub >= h) ? ub - m : ub;
        r = sb ? ua - ub - cl : ua + ub + cl;
        sr = sb ? sa - sbv - cl : sa + sbv + cl;
        res = '0;
        res[15:0] = 16'(r & (m - 1));
        res[16] = (sr < -h) || (sr >= h);
        res[17] = sb ? (r < 0) : (r >= m);
        return res;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // One clock of the 16-bit DUT with scoreboard, stall and hold bookkeeping.
    task automatic tick(output bit acc);
        bit pop, hold;
        logic [17:0] held, e_in, e;
        #1;
        acc = in_valid && in_ready;
        pop = out_valid && out_ready;
        hold = out_valid && !out_ready;
        held = obs;
        e_in = model(16, a, b, c_in, sub);
        chk("in_ready", in_ready, !out_valid || out_ready);
        if (pop) begin
            npop++;
            chk("queue_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("result", obs, e);
            end
        end
        @(posedge clk);
        #1;
        if (acc) exp_q.push_back(e_in);
        if (hold) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", obs, held);
        end
    endtask

    task automatic one_shot(string tag, logic [15:0] va, logic [15:0] vb, logic vc, logic vs,
                            logic [17:0] ve);
        bit acc;
        int n;
        a = va;
        b = vb;
        c_in = vc;
        sub = vs;
        in_valid = 1'b1;
        tick(acc);
        chk({tag, "_accept"}, acc, 1);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            tick(acc);
            n++;
        end
        chk({tag, "_latency"}, n, 4);
        chk(tag, obs, ve);
        tick(acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int i, cyc, pbase;
        string tags[6] = '{"add_wrap", "sub_borrow", "sub_noborrow", "add_ovf", "sub_ovf", "sub_cin"};
        logic [15:0] ta[6] = '{16'hFFFF, 16'h0005, 16'h0007, 16'h7FFF, 16'h8000, 16'h0000};
        logic [15:0] tb[6] = '{16'h0001, 16'h0007, 16'h0005, 16'h0001, 16'h0001, 16'h0000};
        logic tc[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic ts[6] = '{ADD, SUB, SUB, ADD, SUB, SUB};
        logic [17:0] te[6] = '{{2'b10, 16'h0000}, {2'b10, 16'hFFFE}, {2'b00, 16'h0002},
                               {2'b01, 16'h8000}, {2'b01, 16'h7FFF}, {2'b10, 16'hFFFF}};
        bit h1v[1000], h8v[1000];
        logic [17:0] h1e[1000], h8e[1000];

        {in_valid, a, b, c_in, sub} = '0;
        out_ready = 1'b1;
        {iv1, a1, b1, ci1, sb1} = '0;
        {iv8, a8, b8, ci8, sb8} = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outputs", obs, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_w4_valid", ov1, 0);
        chk("rst_w8_valid", ov8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int t = 0; t < 6; t++) one_shot(tags[t], ta[t], tb[t], tc[t], ts[t], te[t]);

        // Streaming with a three-cycle consumer stall mid-stream.
        i = 0;
        cyc = 0;
        pbase = npop;
        while ((i < 8 || exp_q.size() != 0) && cyc < 60) begin
            in_valid = i < 8;
            a = 16'(i);
            b = 16'(i) * 16'h1111;
            c_in = 1'b0;
            sub = ADD;
            out_ready = !(cyc >= 5 && cyc < 8);
            tick(acc);
            if (acc) i++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_sent", i, 8);
        chk("stream_popped", npop - pbase, 8);
        chk("stream_drained", exp_q.size(), 0);

        for (int r = 0; r < 300; r++) begin
            in_valid = $urandom_range(0, 3) != 0;
            a = 16'($urandom);
            b = 16'($urandom);
            c_in = 1'($urandom);
            sub = 1'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            tick(acc);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) tick(acc);
        chk("rand_drained", exp_q.size(), 0);

        // Reset pulse between edges while results are in flight.
        for (int t = 0; t < 4; t++) begin
            in_valid = 1'b1;
            a = 16'($urandom);
            b = 16'($urandom);
            tick(acc);
        end
        in_valid = 1'b0;
        chk("pre_reset_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_async_valid", out_valid, 0);
        chk("reset_async_outputs", obs, 0);
        #2 rst_n = 1'b1;
        exp_q.delete();
        for (int t = 0; t < 10; t++) begin
            tick(acc);
            chk("post_reset_idle", out_valid, 0);
        end
        one_shot("post_reset", 16'h1234, 16'h4321, 1'b0, ADD, {2'b00, 16'h5555});

        // Configuration sweep: latency 1 and 8 with continuous acceptance.
        for (int t = 0; t < 1000; t++) begin
            iv1 = $urandom_range(0, 4) != 0;
            a1 = 4'($urandom);
            b1 = 4'($urandom);
            ci1 = 1'($urandom);
            sb1 = 1'($urandom);
            iv8 = $urandom_range(0, 4) != 0;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            ci8 = 1'($urandom);
            sb8 = 1'($urandom);
            h1v[t] = iv1;
            h1e[t] = model(4, a1, b1, ci1, sb1);
            h8v[t] = iv8;
            h8e[t] = model(8, a8, b8, ci8, sb8);
            #1;
            chk("w4_in_ready", ir1, 1);
            chk("w8_in_ready", ir8, 1);
            @(posedge clk);
            #1;
            chk("w4_valid", ov1, h1v[t]);
            if (h1v[t]) chk("w4_result", {co1, of1, 12'h000, s1}, h1e[t]);
            if (t >= 7) begin
                chk("w8_valid", ov8, h8v[t-7]);
                if (h8v[t-7]) chk("w8_result", {co8, of8, 8'h00, s8}, h8e[t-7]);
            end else begin
                chk("w8_fill", ov8, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised successor to the 4-bit ripple adder: a WIDTH-bit adder/subtractor split into STAGES ripple-carry slices, one slice per pipeline stage.
- Carry is registered between slices. Operand and result bits are skewed and deskewed so each transaction leaves aligned.
- Valid/ready handshake on input and output; one transaction per cycle when not stalled.
- Sits in the datapath wherever the team needs wide adds faster than a full-width ripple allows.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline slices (1..WIDTH); latency in cycles; slice width SW = WIDTH/STAGES.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand transaction present.
- in_ready  out  1  block accepts transaction this cycle.
- a  in  WIDTH  operand A (unsigned or two's complement).
- b  in  WIDTH  operand B.
- c_in  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0: sum = a+b+c_in; 1: sum = a-b-c_in.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- c_out  out  1  carry-out (add) / borrow-out (sub).
- ovf  out  1  signed two's-complement overflow.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, out_valid, sum, c_out and ovf go to 0 immediately. Pipeline data registers go to 0. in_ready follows its equation below.
- Global advance: adv = !out_valid || out_ready. in_ready = adv (combinational, no dependence on in_valid).
- On a clock edge with adv=1:
  - every stage register shifts one stage;
  - stage 0 captures {in_valid, a, b', c_in'}, with b' = sub ? ~b : b and c_in' = sub ? ~c_in : c_in;
  - the sub flag is carried along with the transaction.
- With adv=0, all stage registers hold their values. A held output keeps sum/c_out/ovf stable while out_valid=1.
- Stage k (k=0..STAGES-1):
  - adds slice k of the operands, bits [k*SW +: SW], plus the carry registered from stage k-1 (stage 0 uses c_in');
  - registers the SW-bit partial sum and its carry-out;
  - slices above k are carried forward unchanged; lower result slices are carried forward in deskew registers.
- Latency: a transaction accepted at edge t appears with out_valid=1 after edge t+STAGES-1 and is held until out_valid && out_ready.
- Throughput: 1 per cycle. Bubbles (in_valid=0 while adv=1) travel as invalid stages and are not collapsed.
- c_out:
  - add: raw carry out of the MSB;
  - sub: inverted raw carry, so 1 means borrow (a < b + c_in, unsigned).
- ovf: raw carry-in to the MSB XOR raw carry-out of the MSB, for both modes.
- Simultaneous accept and output (in_valid, in_ready, out_valid, out_ready all 1): both happen in the same edge; nothing is lost or duplicated.
- Release of reset mid-operation: all in-flight transactions are discarded; the first output appears STAGES cycles after the first accepted input.
- STAGES=1: a single registered full-width ripple adder, latency 1.

Decomposition:
- Shared package: constant ADD=1'b0 and SUB=1'b1 for the sub input encoding.
- Sub-module adder_slice:
  - combinational, SW-bit ripple chain of fulladder instances;
  - ports a, b, c_in, sum, c_out, plus c_msb_in for the overflow term;
  - instantiated STAGES times by generate.

Test Plan:
- Add wrap, WIDTH=16/STAGES=4: a=16'hFFFF, b=16'h0001, c_in=0, sub=0 -> 4 cycles later sum=16'h0000, c_out=1, ovf=0.
- Sub borrow: a=16'h0005, b=16'h0007, c_in=0, sub=1 -> sum=16'hFFFE, c_out=1, ovf=0. Same with a=16'h0007, b=16'h0005 -> sum=16'h0002, c_out=0.
- Signed overflow: a=16'h7FFF, b=16'h0001, add -> sum=16'h8000, ovf=1, c_out=0. Sub a=16'h8000, b=16'h0001 -> sum=16'h7FFF, ovf=1.
- Back-to-back streaming: 8 consecutive transactions a=i, b=i*16'h1111; out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, results appear in order with no loss or duplicates, held outputs stable.
- Reset mid-flight: 3 transactions in flight, pulse rst_n low between edges -> out_valid=0 immediately. Nothing emitted after release until new input plus 4 cycles.
- Config sweep WIDTH=4/STAGES=1 and WIDTH=8/STAGES=8: random 1000 vectors vs reference model -> exact match; latencies 1 and 8.
